// File: rtl/hub75_pkg.sv
// hub75_pkg: shared FSM state encoding and default geometry for the HUB75 scan controller
//   DEF_COLS       columns shifted per scan row
//   DEF_SCAN_ROWS  scan rows per frame
//   DEF_ON_CYCLES  clk cycles NOE is held low per row
//   state_e        scan FSM states
package hub75_pkg;
   localparam int DEF_COLS      = 64;
   localparam int DEF_SCAN_ROWS = 32;
   localparam int DEF_ON_CYCLES = 128;
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PRE     = 3'd1,
      ST_SHIFT   = 3'd2,
      ST_BLANK   = 3'd3,
      ST_LATCH   = 3'd4,
      ST_DISPLAY = 3'd5
   } state_e;
endpackage

// File: rtl/hub75_scan_ctrl.sv
// hub75_scan_ctrl: HUB75 panel row scanner (framebuffer fetch, shift, latch, display)
//   clk, rst            clock, asynchronous active-high reset
//   init                scan enable, sampled in IDLE and in the last DISPLAY cycle
//   fb_rd_en, fb_addr   framebuffer read strobe and {row, col} address
//   fb_rgb_top/bot      pixel data, valid one cycle after fb_rd_en
//   LP_CLK, LATCH, NOE  panel shift clock, latch, active-low output enable
//   ROW, RGB0, RGB1     panel row address and top/bottom colour
//   frame_done          one-cycle pulse in the last DISPLAY cycle of the last row
module hub75_scan_ctrl
   import hub75_pkg::*;
#(
   parameter int COLS      = DEF_COLS,
   parameter int SCAN_ROWS = DEF_SCAN_ROWS,
   parameter int ON_CYCLES = DEF_ON_CYCLES
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          init,
   output logic                                          fb_rd_en,
   output logic [$clog2(SCAN_ROWS)+$clog2(COLS)-1:0]     fb_addr,
   input  logic [2:0]                                    fb_rgb_top,
   input  logic [2:0]                                    fb_rgb_bot,
   output logic                                          LP_CLK,
   output logic                                          LATCH,
   output logic                                          NOE,
   output logic [$clog2(SCAN_ROWS)-1:0]                  ROW,
   output logic [2:0]                                    RGB0,
   output logic [2:0]                                    RGB1,
   output logic                                          frame_done
);
   localparam int CW = $clog2(COLS);
   localparam int RW = $clog2(SCAN_ROWS);
   localparam int DW = $clog2(ON_CYCLES + 1);
   localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);
   localparam logic [RW-1:0] R_LAST = RW'(SCAN_ROWS - 1);
   localparam logic [DW-1:0] D_LAST = DW'(ON_CYCLES - 1);
   state_e        state;
   logic          phase;
   logic [CW-1:0] col;
   logic [CW-1:0] next_col;
   logic [CW-1:0] addr_col;
   logic [DW-1:0] disp;
   logic [RW-1:0] row_cnt;
   logic          disp_last;
   assign next_col  = col + 1'b1;
   assign disp_last = (state == ST_DISPLAY) && (disp == D_LAST);
   // PRE fetches column 0; SHIFT P0(c) prefetches column c+1 so it arrives in P1(c)
   assign addr_col   = (state == ST_SHIFT) ? next_col : '0;
   assign fb_rd_en   = !phase && ((state == ST_PRE) || ((state == ST_SHIFT) && (col != C_LAST)));
   assign fb_addr    = fb_rd_en ? {row_cnt, addr_col} : '0;
   assign LP_CLK     = (state == ST_SHIFT) && phase;
   assign LATCH      = (state == ST_LATCH);
   assign NOE        = (state != ST_DISPLAY);
   assign frame_done = disp_last && (row_cnt == R_LAST);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         phase   <= 1'b0;
         col     <= '0;
         disp    <= '0;
         row_cnt <= '0;
         ROW     <= '0;
         RGB0    <= '0;
         RGB1    <= '0;
      end else begin
         case (state)
            ST_IDLE: state <= init ? ST_PRE : ST_IDLE;
            ST_PRE: begin
               phase <= ~phase;
               if (phase) begin
                  state <= ST_SHIFT;
                  RGB0  <= fb_rgb_top;
                  RGB1  <= fb_rgb_bot;
               end
            end
            ST_SHIFT: begin
               phase <= ~phase;
               // pixel for the next column is captured on the P1 -> P0 edge, so RGB
               // stays stable across the whole LP_CLK high phase
               if (phase && (col == C_LAST)) begin
                  state <= ST_BLANK;
                  col   <= '0;
               end else if (phase) begin
                  col  <= next_col;
                  RGB0 <= fb_rgb_top;
                  RGB1 <= fb_rgb_bot;
               end
            end
            ST_BLANK: state <= ST_LATCH;
            ST_LATCH: begin
               state <= ST_DISPLAY;
               ROW   <= row_cnt;
            end
            ST_DISPLAY: begin
               disp <= disp_last ? '0 : disp + 1'b1;
               if (disp_last) begin
                  row_cnt <= (row_cnt == R_LAST) ? '0 : row_cnt + 1'b1;
                  state   <= init ? ST_PRE : ST_IDLE;
                  RGB0    <= init ? RGB0 : 3'b000;
                  RGB1    <= init ? RGB1 : 3'b000;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// tb_hub75_scan_ctrl: directed self-checking bench for hub75_scan_ctrl
module tb_hub75_scan_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        init = 1'b0;
   logic        fb_rd_en;
   logic [10:0] fb_addr;
   logic [2:0]  fb_rgb_top = 3'b000;
   logic [2:0]  fb_rgb_bot = 3'b000;
   logic        LP_CLK, LATCH, NOE, frame_done;
   logic [4:0]  ROW;
   logic [2:0]  RGB0, RGB1;
   int          n_chk = 0;
   int          n_fail = 0;
   int          mode = 0;
   logic        prev_rst = 1'b1;
   logic        prev_noe = 1'b1;
   logic [4:0]  prev_row = '0;
   logic [5:0]  prev_rgb = '0;

   always #5 clk = ~clk;

   hub75_scan_ctrl dut (
      .clk(clk), .rst(rst), .init(init),
      .fb_rd_en(fb_rd_en), .fb_addr(fb_addr),
      .fb_rgb_top(fb_rgb_top), .fb_rgb_bot(fb_rgb_bot),
      .LP_CLK(LP_CLK), .LATCH(LATCH), .NOE(NOE), .ROW(ROW),
      .RGB0(RGB0), .RGB1(RGB1), .frame_done(frame_done)
   );

   // framebuffer: data only valid the cycle after a read strobe
   always @(posedge clk) begin
      if (!fb_rd_en) begin
         fb_rgb_top <= 3'b000;
         fb_rgb_bot <= 3'b000;
      end else if (mode == 0) begin
         fb_rgb_top <= (fb_addr[5:0] == 6'd0) ? 3'b100 : 3'b000;
         fb_rgb_bot <= (fb_addr[5:0] == 6'd0) ? 3'b001 : 3'b000;
      end else begin
         fb_rgb_top <= fb_addr[2:0];
         fb_rgb_bot <= ~fb_addr[2:0];
      end
   end

   always @(negedge clk) begin
      if (!rst && !prev_rst) begin
         n_chk++;
         if (LATCH && !NOE) begin
            n_fail++;
            $display("FAIL inv_latch_noe: LATCH=%b NOE=%b, required NOE=1 while LATCH=1", LATCH, NOE);
         end
         n_chk++;
         if (ROW !== prev_row && !prev_noe) begin
            n_fail++;
            $display("FAIL inv_row_change: ROW %0d->%0d while NOE=0, required change only with NOE=1", prev_row, ROW);
         end
         n_chk++;
         if ({RGB0, RGB1} !== prev_rgb && LP_CLK) begin
            n_fail++;
            $display("FAIL inv_rgb_stable: RGB %h->%h with LP_CLK=1, required stable", prev_rgb, {RGB0, RGB1});
         end
      end
      prev_rst = rst;
      prev_noe = NOE;
      prev_row = ROW;
      prev_rgb = {RGB0, RGB1};
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      init = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_rd(input int lim, output bit ok);
      int t = 0;
      while (fb_rd_en !== 1'b1 && t < lim) begin
         tick();
         t++;
      end
      ok = (fb_rd_en === 1'b1);
   endtask

   task automatic wait_latch(input int lim, output bit ok);
      int t = 0;
      while (LATCH !== 1'b1 && t < lim) begin
         tick();
         t++;
      end
      ok = (LATCH === 1'b1);
   endtask

   task automatic test_reset();
      int bad = 0;
      rst = 1'b1;
      init = 1'b0;
      tick();
      tick();
      n_chk++;
      if ({NOE, LATCH, LP_CLK, fb_rd_en, frame_done} !== 5'b10000) begin
         n_fail++;
         $display("FAIL reset_ctrl: {NOE,LATCH,LP_CLK,rd,fd}=%b, required 10000", {NOE, LATCH, LP_CLK, fb_rd_en, frame_done});
      end
      n_chk++;
      if ({ROW, RGB0, RGB1, fb_addr} !== 22'd0) begin
         n_fail++;
         $display("FAIL reset_data: ROW=%0d RGB0=%b RGB1=%b addr=%0d, required all 0", ROW, RGB0, RGB1, fb_addr);
      end
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (NOE !== 1'b1 || fb_rd_en !== 1'b0) bad++;
      end
      n_chk++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL idle_no_init: %0d active cycles with init=0, required 0", bad);
      end
   endtask

   task automatic test_first_row();
      bit ok;
      int t = 0, rises = 0, low = 0, rowbad = 0;
      logic prev = 1'b0;
      mode = 0;
      do_reset();
      init = 1'b1;
      wait_rd(10, ok);
      n_chk++;
      if (!ok || fb_addr !== 11'd0) begin
         n_fail++;
         $display("FAIL first_addr: rd=%b addr=%0d, required rd=1 addr=0", fb_rd_en, fb_addr);
      end
      while (LATCH !== 1'b1 && t < 400) begin
         tick();
         t++;
         if (LP_CLK && !prev) rises++;
         prev = LP_CLK;
      end
      n_chk++;
      if (t != 131) begin
         n_fail++;
         $display("FAIL latch_delay: LATCH after %0d cycles from first read, required 131", t);
      end
      n_chk++;
      if (rises != 64) begin
         n_fail++;
         $display("FAIL lp_clk_count: %0d rises before LATCH, required 64", rises);
      end
      tick();
      n_chk++;
      if (LATCH !== 1'b0 || NOE !== 1'b0) begin
         n_fail++;
         $display("FAIL latch_width: LATCH=%b NOE=%b after latch cycle, required 0 0", LATCH, NOE);
      end
      while (NOE === 1'b0 && low < 300) begin
         low++;
         if (ROW !== 5'd0) rowbad++;
         tick();
      end
      n_chk++;
      if (low != 128 || rowbad != 0) begin
         n_fail++;
         $display("FAIL display_len: NOE low %0d cycles, %0d with ROW!=0, required 128 and 0", low, rowbad);
      end
      n_chk++;
      if (fb_rd_en !== 1'b1 || fb_addr !== 11'd64) begin
         n_fail++;
         $display("FAIL next_row_addr: rd=%b addr=%0d, required rd=1 addr=64", fb_rd_en, fb_addr);
      end
   endtask

   task automatic test_pixel_data(input int m);
      bit ok;
      int t = 0, k = 0;
      logic prev = 1'b0;
      logic [2:0] et, eb;
      mode = m;
      do_reset();
      init = 1'b1;
      wait_rd(10, ok);
      while (LATCH !== 1'b1 && t < 400) begin
         tick();
         t++;
         if (LP_CLK && !prev) begin
            et = (m == 0) ? ((k == 0) ? 3'b100 : 3'b000) : k[2:0];
            eb = (m == 0) ? ((k == 0) ? 3'b001 : 3'b000) : ~k[2:0];
            n_chk++;
            if (RGB0 !== et || RGB1 !== eb) begin
               n_fail++;
               $display("FAIL pixel_m%0d_col%0d: RGB0=%b RGB1=%b, required %b %b", m, k, RGB0, RGB1, et, eb);
            end
            k++;
         end
         prev = LP_CLK;
      end
      n_chk++;
      if (k != 64) begin
         n_fail++;
         $display("FAIL pixel_m%0d_rises: %0d rises, required 64", m, k);
      end
   endtask

   task automatic test_full_frame();
      int cyc = 0, pulses = 0, last = 0, changes = 0;
      logic [4:0] pr, er;
      mode = 0;
      do_reset();
      init = 1'b1;
      pr = ROW;
      while (cyc < 3 * 8320 + 10) begin
         tick();
         cyc++;
         if (frame_done === 1'b1) begin
            pulses++;
            n_chk++;
            if ((pulses == 1 && cyc != 8320) || (pulses > 1 && cyc - last != 8320)) begin
               n_fail++;
               $display("FAIL frame_period: pulse %0d at cycle %0d (prev %0d), required period 8320", pulses, cyc, last);
            end
            last = cyc;
         end
         if (ROW !== pr) begin
            changes++;
            er = pr + 5'd1;
            n_chk++;
            if (ROW !== er) begin
               n_fail++;
               $display("FAIL row_step: ROW %0d->%0d, required %0d", pr, ROW, er);
            end
            pr = ROW;
         end
      end
      n_chk++;
      if (pulses != 3 || changes != 95) begin
         n_fail++;
         $display("FAIL frame_totals: %0d pulses %0d row changes, required 3 and 95", pulses, changes);
      end
   endtask

   task automatic test_init_drop();
      bit ok;
      int t = 0, bad = 0;
      mode = 0;
      do_reset();
      init = 1'b1;
      while (!(fb_rd_en === 1'b1 && fb_addr[10:6] == 5'd5) && t < 2000) begin
         tick();
         t++;
      end
      n_chk++;
      if (t >= 2000) begin
         n_fail++;
         $display("FAIL drop_reach_row5: no read of row 5 within 2000 cycles, required one");
      end
      for (int i = 0; i < 10; i++) tick();
      init = 1'b0;
      wait_latch(300, ok);
      tick();
      n_chk++;
      if (!ok || ROW !== 5'd5 || NOE !== 1'b0) begin
         n_fail++;
         $display("FAIL drop_row5_display: latched=%b ROW=%0d NOE=%b, required 1 5 0", ok, ROW, NOE);
      end
      t = 0;
      while (NOE !== 1'b1 && t < 200) begin
         tick();
         t++;
      end
      for (int i = 0; i < 20; i++) begin
         if (NOE !== 1'b1 || fb_rd_en !== 1'b0 || ROW !== 5'd5 || RGB0 !== 3'b000 || RGB1 !== 3'b000) bad++;
         tick();
      end
      n_chk++;
      if (t >= 200 || bad != 0) begin
         n_fail++;
         $display("FAIL drop_idle: %0d non-idle cycles (wait %0d), required 0", bad, t);
      end
      init = 1'b1;
      wait_rd(5, ok);
      n_chk++;
      if (!ok || fb_addr !== {5'd6, 6'd0}) begin
         n_fail++;
         $display("FAIL drop_resume: rd=%b addr row=%0d col=%0d, required row 6 col 0", ok, fb_addr[10:6], fb_addr[5:0]);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int t = 0;
      mode = 0;
      do_reset();
      init = 1'b1;
      while (!(ROW === 5'd2 && NOE === 1'b0) && t < 1000) begin
         tick();
         t++;
      end
      for (int i = 0; i < 5; i++) tick();
      n_chk++;
      if (NOE !== 1'b0 || ROW !== 5'd2) begin
         n_fail++;
         $display("FAIL mid_setup: NOE=%b ROW=%0d, required 0 2", NOE, ROW);
      end
      #2 rst = 1'b1;
      #1;
      n_chk++;
      if ({NOE, LATCH, LP_CLK, fb_rd_en, frame_done} !== 5'b10000) begin
         n_fail++;
         $display("FAIL mid_reset_ctrl: {NOE,LATCH,LP_CLK,rd,fd}=%b, required 10000", {NOE, LATCH, LP_CLK, fb_rd_en, frame_done});
      end
      n_chk++;
      if ({ROW, RGB0, RGB1, fb_addr} !== 22'd0) begin
         n_fail++;
         $display("FAIL mid_reset_data: ROW=%0d RGB0=%b RGB1=%b addr=%0d, required all 0", ROW, RGB0, RGB1, fb_addr);
      end
      tick();
      tick();
      rst = 1'b0;
      wait_rd(10, ok);
      n_chk++;
      if (!ok || fb_addr !== 11'd0) begin
         n_fail++;
         $display("FAIL mid_restart_addr: rd=%b addr=%0d, required rd=1 addr=0", ok, fb_addr);
      end
      wait_latch(300, ok);
      tick();
      n_chk++;
      if (!ok || ROW !== 5'd0 || NOE !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_restart_row: latched=%b ROW=%0d NOE=%b, required 1 0 0", ok, ROW, NOE);
      end
   endtask

   initial begin
      test_reset();
      test_first_row();
      test_pixel_data(0);
      test_pixel_data(1);
      test_full_frame();
      test_init_drop();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
